// File: rtl/safety_island_boot_ctrl.sv
// rtl/safety_island_boot_ctrl.sv - safety island boot control registers and boot FSM
//
// Purpose: small register block (BOOTADDR, FETCHEN, CORESTATUS, BOOTMODE)
// behind a simple valid/ready register bus, plus the FSM that decides when
// the safety core may start fetching.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   bootmode_i         boot strap (01 = Preloaded, anything else = Jtag)
//   reg_valid_i        request valid, held with addr/data until reg_ready_o
//   reg_write_i        1 = write, 0 = read
//   reg_addr_i         byte address, bits [11:2] select the register
//   reg_wdata_i        write data
//   reg_wstrb_i        write byte enables
//   reg_ready_o        one-cycle response strobe
//   reg_rdata_o        read data (0 outside the ready cycle)
//   reg_error_o        error response, qualified by reg_ready_o
//   boot_addr_o        current BOOTADDR
//   fetch_en_o         core fetch enable (high only in RUN)
//   eoc_o              end-of-computation flag, CORESTATUS[31]
module safety_island_boot_ctrl #(
  parameter logic [31:0] BootAddrDefault = 32'h0000_1080,
  parameter int unsigned AddrWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           bootmode_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_en_o,
  output logic                 eoc_o
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StSample   = 3'd1,
    StWaitJtag = 3'd2,
    StWaitLoad = 3'd3,
    StRun      = 3'd4,
    StHalt     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;      // 1 = Preloaded, 0 = Jtag
  logic        ready_q, ready_d;
  logic [31:0] bootaddr_q, bootaddr_d;
  logic [31:0] corestatus_q, corestatus_d;

  logic [9:0]  word_idx;
  logic        sel_bootaddr, sel_fetchen, sel_corestatus, sel_bootmode;
  logic        bus_err, commit;
  logic        fe_wr, boot_wr;
  logic [31:0] wmask, rdata_mux;
  logic        unused_addr;

  assign word_idx       = reg_addr_i[11:2];
  assign unused_addr    = ^{reg_addr_i[AddrWidth-1:12], reg_addr_i[1:0]};
  assign sel_bootaddr   = (word_idx == 10'd0);
  assign sel_fetchen    = (word_idx == 10'd1);
  assign sel_corestatus = (word_idx == 10'd2);
  assign sel_bootmode   = (word_idx == 10'd3);

  assign bus_err = ~(sel_bootaddr | sel_fetchen | sel_corestatus | sel_bootmode)
                 | (sel_bootmode & reg_write_i);

  // Writes land on the edge that closes the ready cycle.
  assign commit  = ready_q & reg_valid_i & reg_write_i & ~bus_err;
  assign fe_wr   = commit & sel_fetchen & reg_wstrb_i[0];
  assign boot_wr = commit & sel_bootaddr & (|reg_wstrb_i);
  assign wmask   = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                    {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};

  // A ready cycle is always followed by an idle cycle, even if valid stays high.
  assign ready_d = reg_valid_i & ~ready_q;

  assign bootaddr_d   = (commit & sel_bootaddr)
                      ? ((bootaddr_q & ~wmask) | (reg_wdata_i & wmask)) : bootaddr_q;
  assign corestatus_d = (commit & sel_corestatus)
                      ? ((corestatus_q & ~wmask) | (reg_wdata_i & wmask)) : corestatus_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      StReset:  state_d = StSample;
      StSample: begin
        mode_d  = (bootmode_i == 2'b01);
        state_d = (bootmode_i == 2'b01) ? StWaitLoad : StWaitJtag;
      end
      StWaitJtag: if (fe_wr && reg_wdata_i[0])  state_d = StRun;
      StWaitLoad: if (boot_wr)                  state_d = StRun;
      StRun:      if (fe_wr && !reg_wdata_i[0]) state_d = StHalt;
      StHalt:     if (fe_wr && reg_wdata_i[0])  state_d = StRun;
      default:    state_d = StReset;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StReset;
      mode_q       <= 1'b0;
      ready_q      <= 1'b0;
      bootaddr_q   <= BootAddrDefault;
      corestatus_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ready_q      <= ready_d;
      bootaddr_q   <= bootaddr_d;
      corestatus_q <= corestatus_d;
    end
  end

  // FETCHEN has no storage of its own: it is the RUN state.
  assign fetch_en_o = (state_q == StRun);

  always_comb begin
    rdata_mux = 32'h0;
    if (sel_bootaddr)   rdata_mux = bootaddr_q;
    if (sel_fetchen)    rdata_mux = {31'h0, fetch_en_o};
    if (sel_corestatus) rdata_mux = corestatus_q;
    if (sel_bootmode)   rdata_mux = {30'h0, 1'b0, mode_q};
  end

  assign reg_ready_o = ready_q;
  assign reg_error_o = ready_q & bus_err;
  assign reg_rdata_o = (ready_q & ~reg_write_i & ~bus_err) ? rdata_mux : 32'h0;
  assign boot_addr_o = bootaddr_q;
  assign eoc_o       = corestatus_q[31];

endmodule
